// File: rtl/tttg_2x2.sv
// Two-player tic-tac-toe controller on a 2x2 board with win/draw detection and a game-over lock.
// Optional TTTG_BUTTON_EDGE_EN: a move also requires the previous-cycle button to have been released.
module tttg_2x2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       play1,
    input  logic       play2,
    input  logic [3:0] button,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] who,
    output logic [1:0] present_state
);

    typedef enum logic [1:0] {
        P1_TURN   = 2'b00,
        P2_TURN   = 2'b01,
        GAME_DONE = 2'b10,
        ILLEGAL   = 2'b11
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] cell_q [4];
    logic [1:0] cell_d [4];
    logic [1:0] who_q, who_d;

    logic       oneHot;
    logic [1:0] selIdx;
    logic [1:0] mark;
    logic       turnPlay;
    logic       edgeOk;
    logic       moveValid;
    logic       win;
    logic       full;

`ifdef TTTG_BUTTON_EDGE_EN
    logic [3:0] btnPrev_q;
    assign edgeOk = (btnPrev_q == 4'b0000);
`else
    assign edgeOk = 1'b1;
`endif

    function automatic logic lineWin(input logic [1:0] a, input logic [1:0] b);
        return (a != 2'b00) && (a == b);
    endfunction

    // Cell index 0..3 maps to cell1..cell4; button[3] selects cell1.
    always_comb begin
        oneHot   = (button != 4'b0000) && ((button & (button - 4'd1)) == 4'b0000);
        selIdx   = 2'd0;
        case (button)
            4'b1000: selIdx = 2'd0;
            4'b0100: selIdx = 2'd1;
            4'b0010: selIdx = 2'd2;
            4'b0001: selIdx = 2'd3;
            default: selIdx = 2'd0;
        endcase
        mark      = (state_q == P1_TURN) ? 2'b01 : 2'b10;
        turnPlay  = ((state_q == P1_TURN) && play1) || ((state_q == P2_TURN) && play2);
        moveValid = turnPlay && oneHot && edgeOk && (cell_q[selIdx] == 2'b00);

        cell_d = cell_q;
        if (moveValid) begin
            cell_d[selIdx] = mark;
        end

        // Win is judged on the board including this move so the result lands on the same edge.
        win  = lineWin(cell_d[0], cell_d[1]) || lineWin(cell_d[2], cell_d[3]) ||
               lineWin(cell_d[0], cell_d[2]) || lineWin(cell_d[1], cell_d[3]) ||
               lineWin(cell_d[0], cell_d[3]) || lineWin(cell_d[1], cell_d[2]);
        full = (cell_d[0] != 2'b00) && (cell_d[1] != 2'b00) &&
               (cell_d[2] != 2'b00) && (cell_d[3] != 2'b00);

        state_d = state_q;
        who_d   = who_q;
        case (state_q)
            P1_TURN, P2_TURN: begin
                if (moveValid) begin
                    if (win) begin
                        who_d   = mark;
                        state_d = GAME_DONE;
                    end else if (full) begin
                        who_d   = 2'b11;
                        state_d = GAME_DONE;
                    end else begin
                        state_d = (state_q == P1_TURN) ? P2_TURN : P1_TURN;
                    end
                end
            end
            GAME_DONE: state_d = GAME_DONE;
            default:   state_d = P1_TURN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= P1_TURN;
            who_q   <= 2'b00;
            for (int i = 0; i < 4; i++) begin
                cell_q[i] <= 2'b00;
            end
`ifdef TTTG_BUTTON_EDGE_EN
            btnPrev_q <= 4'b0000;
`endif
        end else begin
            state_q <= state_d;
            who_q   <= who_d;
            for (int i = 0; i < 4; i++) begin
                cell_q[i] <= cell_d[i];
            end
`ifdef TTTG_BUTTON_EDGE_EN
            btnPrev_q <= button;
`endif
        end
    end

    assign pos1          = cell_q[0];
    assign pos2          = cell_q[1];
    assign pos3          = cell_q[2];
    assign pos4          = cell_q[3];
    assign who           = who_q;
    assign present_state = state_q;

endmodule

// File: tb/tb_tttg_2x2.sv
// Self-checking bench for tttg_2x2: directed game scenarios plus randomized play against a
// reference model that judges wins by counting each player's marks.
module tb_tttg_2x2;

    logic       clk = 1'b0;
    logic       reset;
    logic       play1;
    logic       play2;
    logic [3:0] button;
    logic [1:0] pos1, pos2, pos3, pos4, who, present_state;

    int checks = 0;
    int errors = 0;

    int         mCell [4];
    int         mState;
    int         mWho;
    logic [3:0] mPrevBtn;

    tttg_2x2 dut (
        .clk          (clk),
        .reset        (reset),
        .play1        (play1),
        .play2        (play2),
        .button       (button),
        .pos1         (pos1),
        .pos2         (pos2),
        .pos3         (pos3),
        .pos4         (pos4),
        .who          (who),
        .present_state(present_state)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] dutVec();
        return {pos1, pos2, pos3, pos4, who, present_state};
    endfunction

    function automatic logic [11:0] expVec();
        return {2'(mCell[0]), 2'(mCell[1]), 2'(mCell[2]), 2'(mCell[3]), 2'(mWho), 2'(mState)};
    endfunction

    // Game rules: the mover's second mark wins; a full board without a win is a draw.
    task automatic modelStep(input logic r, input logic p1, input logic p2, input logic [3:0] btn);
        int   player;
        int   idx;
        int   cnt;
        int   filled;
        logic play;
        if (!r) begin
            for (int i = 0; i < 4; i++) mCell[i] = 0;
            mState   = 0;
            mWho     = 0;
            mPrevBtn = 4'b0000;
            return;
        end
        if (mState != 2) begin
            player = (mState == 0) ? 1 : 2;
            play   = (player == 1) ? p1 : p2;
            idx    = -1;
            if ($countones(btn) == 1) begin
                for (int i = 0; i < 4; i++) if (btn[3-i]) idx = i;
            end
`ifdef TTTG_BUTTON_EDGE_EN
            if (mPrevBtn != 4'b0000) idx = -1;
`endif
            if (play && idx >= 0 && mCell[idx] == 0) begin
                mCell[idx] = player;
                cnt    = 0;
                filled = 0;
                for (int i = 0; i < 4; i++) begin
                    if (mCell[i] == player) cnt++;
                    if (mCell[i] != 0) filled++;
                end
                if (cnt >= 2) begin
                    mWho   = player;
                    mState = 2;
                end else if (filled == 4) begin
                    mWho   = 3;
                    mState = 2;
                end else begin
                    mState = (player == 1) ? 1 : 0;
                end
            end
        end
        mPrevBtn = btn;
    endtask

    // Called at a falling edge; drives inputs, advances the model and returns at the next falling edge.
    task automatic applyCycle(input logic r, input logic p1, input logic p2, input logic [3:0] btn);
        reset  = r;
        play1  = p1;
        play2  = p2;
        button = btn;
        modelStep(r, p1, p2, btn);
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyCycle(1'b1, 1'b0, 1'b0, 4'b0000);
    endtask

    task automatic test_reset();
        repeat (100) applyCycle(1'b0, 1'b0, 1'b0, 4'b0000);
        checks++;
        if (dutVec() !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_hold: got %b expected %b", dutVec(), 12'h000);
        end
        idleCycle();
        checks++;
        if (dutVec() !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_release: got %b expected %b", dutVec(), 12'h000);
        end
    endtask

    task automatic test_p1_win();
        repeat (100) applyCycle(1'b1, 1'b1, 1'b0, 4'b1000);
        checks++;
        if ({pos1, present_state} !== 4'b01_01) begin
            errors++;
            $display("[TB] FAIL p1_cell1: got pos1/state %b expected %b", {pos1, present_state}, 4'b0101);
        end
        idleCycle();
        repeat (100) applyCycle(1'b1, 1'b0, 1'b1, 4'b0100);
        checks++;
        if ({pos2, present_state} !== 4'b10_00) begin
            errors++;
            $display("[TB] FAIL p2_cell2: got pos2/state %b expected %b", {pos2, present_state}, 4'b1000);
        end
        idleCycle();
        applyCycle(1'b1, 1'b1, 1'b0, 4'b0010);
        checks++;
        if ({pos3, who, present_state} !== 6'b01_01_10) begin
            errors++;
            $display("[TB] FAIL p1_win_edge: got pos3/who/state %b expected %b", {pos3, who, present_state}, 6'b010110);
        end
        repeat (99) applyCycle(1'b1, 1'b1, 1'b0, 4'b0010);
        idleCycle();
        checks++;
        if (dutVec() !== 12'b01_10_01_00_01_10) begin
            errors++;
            $display("[TB] FAIL p1_win_board: got %b expected %b", dutVec(), 12'b011001000110);
        end
    endtask

    task automatic test_after_done();
        repeat (10) applyCycle(1'b1, 1'b0, 1'b1, 4'b0001);
        repeat (10) applyCycle(1'b1, 1'b1, 1'b1, 4'b0001);
        checks++;
        if ({pos4, who, present_state} !== 6'b00_01_10) begin
            errors++;
            $display("[TB] FAIL done_locked: got pos4/who/state %b expected %b", {pos4, who, present_state}, 6'b000110);
        end
    endtask

    task automatic test_p2_offturn();
        applyCycle(1'b0, 1'b0, 1'b0, 4'b0000);
        applyCycle(1'b1, 1'b1, 1'b0, 4'b1000);
        idleCycle();
        applyCycle(1'b1, 1'b0, 1'b1, 4'b0100);
        idleCycle();
        repeat (3) applyCycle(1'b1, 1'b1, 1'b0, 4'b0000);
        repeat (5) applyCycle(1'b1, 1'b0, 1'b1, 4'b0001);
        checks++;
        if (dutVec() !== 12'b01_10_00_00_00_00) begin
            errors++;
            $display("[TB] FAIL p2_offturn: got %b expected %b", dutVec(), 12'b011000000000);
        end
    endtask

    task automatic test_invalid();
        logic [3:0] badBtn [3] = '{4'b1100, 4'b0000, 4'b1111};
        applyCycle(1'b0, 1'b0, 1'b0, 4'b0000);
        foreach (badBtn[k]) begin
            applyCycle(1'b1, 1'b1, 1'b0, badBtn[k]);
            checks++;
            if (dutVec() !== 12'h000) begin
                errors++;
                $display("[TB] FAIL invalid_btn_%b: got %b expected %b", badBtn[k], dutVec(), 12'h000);
            end
        end
        applyCycle(1'b1, 1'b0, 1'b1, 4'b1000);
        checks++;
        if (dutVec() !== 12'h000) begin
            errors++;
            $display("[TB] FAIL invalid_offturn: got %b expected %b", dutVec(), 12'h000);
        end
    endtask

    task automatic test_occupied();
        applyCycle(1'b0, 1'b0, 1'b0, 4'b0000);
        applyCycle(1'b1, 1'b1, 1'b0, 4'b1000);
        idleCycle();
        repeat (5) applyCycle(1'b1, 1'b0, 1'b1, 4'b1000);
        checks++;
        if (dutVec() !== 12'b01_00_00_00_00_01) begin
            errors++;
            $display("[TB] FAIL occupied: got %b expected %b", dutVec(), 12'b010000000001);
        end
    endtask

    task automatic test_hold_both();
        applyCycle(1'b0, 1'b0, 1'b0, 4'b0000);
        repeat (6) applyCycle(1'b1, 1'b1, 1'b1, 4'b1000);
        checks++;
        if (dutVec() !== 12'b01_00_00_00_00_01) begin
            errors++;
            $display("[TB] FAIL hold_both: got %b expected %b", dutVec(), 12'b010000000001);
        end
    endtask

    task automatic test_midgame_reset();
        applyCycle(1'b0, 1'b0, 1'b0, 4'b0000);
        applyCycle(1'b1, 1'b1, 1'b0, 4'b0010);
        idleCycle();
        applyCycle(1'b1, 1'b0, 1'b1, 4'b0001);
        applyCycle(1'b0, 1'b1, 1'b1, 4'b0100);
        checks++;
        if (dutVec() !== 12'h000) begin
            errors++;
            $display("[TB] FAIL midgame_reset: got %b expected %b", dutVec(), 12'h000);
        end
        applyCycle(1'b1, 1'b1, 1'b0, 4'b1000);
        idleCycle();
        applyCycle(1'b1, 1'b0, 1'b1, 4'b0100);
        idleCycle();
        applyCycle(1'b1, 1'b1, 1'b0, 4'b0001);
        applyCycle(1'b0, 1'b0, 1'b0, 4'b0000);
        checks++;
        if (dutVec() !== 12'h000) begin
            errors++;
            $display("[TB] FAIL done_reset: got %b expected %b", dutVec(), 12'h000);
        end
    endtask

    task automatic test_random();
        logic       r;
        logic [3:0] btn;
        int         kind;
        int         doneCycles;
        applyCycle(1'b0, 1'b0, 1'b0, 4'b0000);
        doneCycles = 0;
        for (int n = 0; n < 1500; n++) begin
            doneCycles = (mState == 2) ? doneCycles + 1 : 0;
            r    = !(($urandom_range(0, 59) == 0) || (doneCycles > 4));
            kind = $urandom_range(0, 3);
            if (kind < 2)       btn = 4'b0001 << $urandom_range(0, 3);
            else if (kind == 2) btn = 4'b0000;
            else                btn = 4'($urandom);
            applyCycle(r, 1'($urandom), 1'($urandom), btn);
            checks++;
            if (dutVec() !== expVec()) begin
                errors++;
                $display("[TB] FAIL random_%0d: got %b expected %b", n, dutVec(), expVec());
            end
        end
    endtask

    initial begin
        reset  = 1'b0;
        play1  = 1'b0;
        play2  = 1'b0;
        button = 4'b0000;
        @(negedge clk);
        test_reset();
        test_p1_win();
        test_after_done();
        test_p2_offturn();
        test_invalid();
        test_occupied();
        test_hold_both();
        test_midgame_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
